// File: rtl/dff_link_pipe.sv
// Registered delay line of DEPTH stages with per-stage valid, stall, flush,
// a runtime-selectable output tap and a running count of occupied stages.
module dff_link_pipe #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           input_data,
    input  logic                       input_valid,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           output_data,
    output logic                       output_valid,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);

    localparam int TAP_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(DEPTH - 1);

    // Valid has no handshake: input_valid only tags the word entering stage 0
    // on an enabled edge, and rides along with it; there is no ready/backpressure,
    // upstream throttles itself from fill_count.
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [CNT_W-1:0] fill_q;
    logic [TAP_W-1:0] tap_eff;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
            valid_q <= '0;
            fill_q  <= '0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) data_q[k] <= RESET_VALUE;
            valid_q <= '0;
            fill_q  <= '0;
        end else if (enable) begin
            data_q[0] <= input_data;
            for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
            valid_q <= {valid_q[DEPTH-2:0], input_valid};
            // Entry and exit on the same edge cancel out.
            fill_q  <= fill_q + CNT_W'(input_valid) - CNT_W'(valid_q[DEPTH-1]);
        end
    end

    // Out-of-range taps only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << TAP_W)) begin : g_no_clamp
            assign tap_eff = tap_sel;
        end else begin : g_clamp
            assign tap_eff = (tap_sel > LAST_TAP) ? LAST_TAP : tap_sel;
        end
    endgenerate

    always_comb begin
        output_data  = data_q[tap_eff];
        output_valid = valid_q[tap_eff];
    end

    assign fill_count = fill_q;

endmodule

// File: tb/tb_dff_link_pipe.sv
// Bench for dff_link_pipe: an 8x4 and a 12x7 instance driven together and
// compared every cycle against queue-based models of the stage contents.
module tb_dff_link_pipe;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        enable, flush;
    logic [7:0]  d_a;
    logic        v_a;
    logic [1:0]  tap_a;
    logic [7:0]  od_a;
    logic        ov_a;
    logic [2:0]  fc_a;
    logic [11:0] d_b;
    logic        v_b;
    logic [2:0]  tap_b;
    logic [11:0] od_b;
    logic        ov_b;
    logic [2:0]  fc_b;

    dff_link_pipe #(.WIDTH(8), .DEPTH(4)) dut_a (
        .CLK(CLK), .RST(RST), .input_data(d_a), .input_valid(v_a),
        .enable(enable), .flush(flush), .tap_sel(tap_a),
        .output_data(od_a), .output_valid(ov_a), .fill_count(fc_a)
    );

    dff_link_pipe #(.WIDTH(12), .DEPTH(7)) dut_b (
        .CLK(CLK), .RST(RST), .input_data(d_b), .input_valid(v_b),
        .enable(enable), .flush(flush), .tap_sel(tap_b),
        .output_data(od_b), .output_valid(ov_b), .fill_count(fc_b)
    );

    // Front of each queue is stage 0; entries are {valid, data}.
    logic [8:0]  exp_q_a[$];
    logic [12:0] exp_q_b[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q_a.delete();
        exp_q_b.delete();
        repeat (4) exp_q_a.push_back(9'h000);
        repeat (7) exp_q_b.push_back(13'h0000);
    endtask

    task automatic model_edge();
        if (!RST || flush) begin
            model_clear();
        end else if (enable) begin
            exp_q_a.push_front({v_a, d_a});
            void'(exp_q_a.pop_back());
            exp_q_b.push_front({v_b, d_b});
            void'(exp_q_b.pop_back());
        end
    endtask

    task automatic check_all();
        int ia, ib, pa, pb;
        ia = int'(tap_a);
        ib = (int'(tap_b) > 6) ? 6 : int'(tap_b);
        pa = 0;
        pb = 0;
        foreach (exp_q_a[i]) pa += int'(exp_q_a[i][8]);
        foreach (exp_q_b[i]) pb += int'(exp_q_b[i][12]);
        check("a_data",  od_a, exp_q_a[ia][7:0]);
        check("a_valid", ov_a, exp_q_a[ia][8]);
        check("a_fill",  fc_a, pa);
        check("b_data",  od_b, exp_q_b[ib][11:0]);
        check("b_valid", ov_b, exp_q_b[ib][12]);
        check("b_fill",  fc_b, pb);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    logic [7:0] seen[$];
    logic [2:0] frozen;

    initial begin
        RST = 1'b0;
        enable = 1'($urandom_range(0, 1));
        flush  = 1'b0;
        d_a = 8'($urandom); v_a = 1'b1; tap_a = 2'd3;
        d_b = 12'($urandom); v_b = 1'b1; tap_b = 3'd7;
        model_clear();
        #1;
        check_all();

        // Reset holds everything at zero regardless of inputs
        repeat (3) begin
            enable = 1'($urandom_range(0, 1));
            d_a = 8'($urandom);
            d_b = 12'($urandom);
            tick();
            check("rst_valid", ov_a, 1'b0);
        end
        RST = 1'b1;
        enable = 1'b1; v_a = 1'b0; v_b = 1'b0;
        tick();
        check("rst_rel_fill", fc_a, 3'd0);

        // Latency through tap 3
        tap_a = 2'd3;
        for (int i = 0; i < 5; i++) begin
            d_a = 8'(8'h11 * (i + 1));
            v_a = 1'b1;
            tick();
            check("lat_fill", fc_a, (i < 3) ? i + 1 : 4);
            if (i == 3) begin check("lat_out", od_a, 8'h11); check("lat_v", ov_a, 1'b1); end
            if (i == 4) check("lat_out", od_a, 8'h22);
        end
        v_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lat_tail", od_a, 8'(8'h33 + 8'h11 * i));
        end

        // Tap sweep on a full, stalled pipe
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_a = 8'(8'hA0 + i); v_a = 1'b1; tick();
        end
        enable = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap_a = 2'(t);
            #1;
            check_all();
            check("sweep_data", od_a, 8'(8'hA3 - t));
            check("sweep_valid", ov_a, 1'b1);
        end
        tick();
        check("sweep_hold_fill", fc_a, 3'd4);

        // Stall mid-stream: order preserved, count frozen
        tap_a = 2'd3;
        enable = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
        seen.delete();
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) begin
                enable = 1'b0;
                frozen = fc_a;
                repeat (3) begin
                    d_a = 8'($urandom); v_a = 1'($urandom_range(0, 1));
                    tick();
                    check("stall_fill", fc_a, frozen);
                end
                enable = 1'b1;
            end
            d_a = 8'(i); v_a = 1'b1; tick();
            if (ov_a) seen.push_back(od_a);
        end
        v_a = 1'b0;
        repeat (4) begin
            tick();
            if (ov_a) seen.push_back(od_a);
        end
        check("stall_count", seen.size(), 8);
        foreach (seen[i]) check("stall_order", seen[i], i + 1);

        // Flush beats enable and discards the incoming word
        for (int i = 0; i < 4; i++) begin
            d_a = 8'($urandom); v_a = 1'b1; tick();
        end
        check("flush_pre_fill", fc_a, 3'd4);
        flush = 1'b1; d_a = 8'hFF; v_a = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_fill", fc_a, 3'd0);
        check("flush_valid", ov_a, 1'b0);
        check("flush_data", od_a, 8'h00);
        v_a = 1'b0;
        repeat (4) begin
            tick();
            check("flush_no_ff", ov_a, 1'b0);
        end

        // Random traffic on both instances, with an async reset pulse
        for (int cyc = 0; cyc < 300; cyc++) begin
            enable = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 39) == 0);
            d_a = 8'($urandom);  v_a = 1'($urandom_range(0, 1));
            d_b = 12'($urandom); v_b = 1'(cyc % 2);
            tap_a = 2'($urandom_range(0, 3));
            tap_b = (cyc % 3 == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            tick();
            if (cyc == 150) begin
                #2;
                RST = 1'b0;
                model_clear();
                #1;
                check_all();
                check("arst_fill_b", fc_b, 3'd0);
                check("arst_valid_b", ov_b, 1'b0);
                #1;
                RST = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
